// File: rtl/hram_cmd_parser_pkg.sv
// rtl/hram_cmd_parser_pkg.sv - command codes, response constants and FSM encodings for hram_cmd_parser
package hram_cmd_pkg;

    localparam int FRAME_BYTES = 5;
    localparam int RESP_BYTES  = 4;

    localparam logic [7:0] CMD_ADDR     = 8'h01;
    localparam logic [7:0] CMD_LOAD     = 8'h02;
    localparam logic [7:0] CMD_WRITE    = 8'h03;
    localparam logic [7:0] CMD_READ     = 8'h04;
    localparam logic [7:0] CMD_READ_REQ = 8'h05;
    localparam logic [7:0] CMD_COUNT    = 8'h06;
    localparam logic [7:0] CMD_CONST    = 8'h07;

    localparam logic [31:0] RESP_WRITE    = 32'h0000_0003;
    localparam logic [31:0] RESP_READ_REQ = 32'h0000_0005;
    localparam logic [31:0] RESP_CONST    = 32'h0000_0103;
    localparam logic [31:0] RESP_BAD      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        PS_RX,
        PS_EXEC,
        PS_MEM_WAIT,
        PS_RESP
    } parse_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_TX_START,
        SER_TX_LOW,
        SER_TX_HIGH
    } ser_state_t;

    function automatic logic is_mem_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WRITE) || (cmd == CMD_READ_REQ);
    endfunction

endpackage

// File: rtl/hram_cmd_parser_if.sv
// rtl/hram_cmd_parser_if.sv - uart and hyper_xface side signals of the command parser
interface hram_cmd_parser_if;
    logic        rx_rcv;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        mem_busy;
    logic        rd_rdy;
    logic [31:0] rd_d;
    logic [31:0] addr;
    logic [31:0] wr_d;
    logic        wr_req;
    logic        rd_req;
    logic        frame_err;

    modport master (
        input  rx_rcv, rx_data, tx_ready, mem_busy, rd_rdy, rd_d,
        output tx_start, tx_data, addr, wr_d, wr_req, rd_req, frame_err
    );

    modport slave (
        output rx_rcv, rx_data, tx_ready, mem_busy, rd_rdy, rd_d,
        input  tx_start, tx_data, addr, wr_d, wr_req, rd_req, frame_err
    );
endinterface

// File: rtl/hram_resp_serializer.sv
// rtl/hram_resp_serializer.sv - sends a 32-bit response MSB first as four uart_tx bytes
module hram_resp_serializer
    import hram_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] resp_in,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done
);

    ser_state_t  state, state_nx;
    logic [31:0] shreg;
    logic [2:0]  tx_left;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= SER_IDLE;
            shreg   <= '0;
            tx_left <= '0;
        end else begin
            state <= state_nx;
            if (load && state == SER_IDLE) begin
                shreg   <= resp_in;
                tx_left <= 3'(RESP_BYTES);
            end else if (state == SER_TX_LOW && !tx_ready) begin
                shreg   <= {shreg[23:0], 8'h00};
                tx_left <= tx_left - 3'd1;
            end
        end
    end

    // uart_tx acknowledges a start by dropping tx_ready; only then is the byte committed
    always_comb begin
        state_nx = state;
        tx_start = 1'b0;
        done     = 1'b0;
        unique case (state)
            SER_IDLE:     if (load) state_nx = SER_TX_START;
            SER_TX_START: if (tx_ready) begin
                tx_start = 1'b1;
                state_nx = SER_TX_LOW;
            end
            SER_TX_LOW:   if (!tx_ready) state_nx = SER_TX_HIGH;
            SER_TX_HIGH:  if (tx_ready) begin
                if (tx_left == 3'd0) begin
                    done     = 1'b1;
                    state_nx = SER_IDLE;
                end else begin
                    state_nx = SER_TX_START;
                end
            end
            default:      state_nx = SER_IDLE;
        endcase
    end

    assign tx_data = shreg[31:24];
    assign busy    = (state != SER_IDLE);

endmodule

// File: rtl/hram_cmd_parser.sv
// rtl/hram_cmd_parser.sv - 5-byte serial command engine driving hyper_xface; CMD_TIMEOUT_EN adds partial-frame timeout
module hram_cmd_parser
    import hram_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2400000,
    parameter int CNT_W          = 22
)
(
    input  logic              clk,
    input  logic              rstn,
    hram_cmd_parser_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_timeout
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    parse_state_t state, state_nx;
    logic [39:0]  frame;
    logic [2:0]   byte_cnt;
    logic [31:0]  addr_q, wr_d_q, rd_latch, count;
    logic         frame_err_q;
    logic [7:0]   cmd;
    logic [31:0]  data;
    logic [31:0]  resp;
    logic         shift_en, frame_done, drop, exec_apply;
    logic         wr_req_c, rd_req_c;
    logic         ser_load, ser_busy, ser_done, ser_tx_start;
    logic [7:0]   ser_tx_data;
    logic         timeout_hit;

    assign cmd  = frame[39:32];
    assign data = frame[31:0];

`ifdef CMD_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt;

    assign timeout_hit = (state == PS_RX) && (byte_cnt != 3'd0) &&
                         (byte_cnt != 3'(FRAME_BYTES)) && !bus.rx_rcv &&
                         (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            idle_cnt <= '0;
        else if (state != PS_RX || byte_cnt == 3'd0 || bus.rx_rcv || timeout_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= PS_RX;
            frame       <= '0;
            byte_cnt    <= '0;
            addr_q      <= '0;
            wr_d_q      <= '0;
            rd_latch    <= '0;
            count       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (bus.rd_rdy)
                rd_latch <= bus.rd_d;
            if (drop)
                frame_err_q <= 1'b1;
            if (shift_en) begin
                frame    <= {frame[31:0], bus.rx_data};
                byte_cnt <= byte_cnt + 3'd1;
            end else if (frame_done || timeout_hit) begin
                byte_cnt <= '0;
            end
            if (exec_apply) begin
                case (cmd)
                    CMD_ADDR:  addr_q <= data;
                    CMD_LOAD:  wr_d_q <= data;
                    CMD_COUNT: count  <= count + 32'd1;
                    default:   ;
                endcase
            end
        end
    end

    // A byte landing on the cycle a full frame hands off to EXEC is treated as outside RX
    always_comb begin
        state_nx   = state;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        drop       = 1'b0;
        exec_apply = 1'b0;
        ser_load   = 1'b0;
        wr_req_c   = 1'b0;
        rd_req_c   = 1'b0;
        unique case (state)
            PS_RX: begin
                if (byte_cnt == 3'(FRAME_BYTES)) begin
                    frame_done = 1'b1;
                    drop       = bus.rx_rcv;
                    state_nx   = PS_EXEC;
                end else begin
                    shift_en = bus.rx_rcv;
                end
            end
            PS_EXEC: begin
                drop = bus.rx_rcv;
                if (!ser_busy) begin
                    if (is_mem_cmd(cmd)) begin
                        state_nx = PS_MEM_WAIT;
                    end else begin
                        exec_apply = 1'b1;
                        ser_load   = 1'b1;
                        state_nx   = PS_RESP;
                    end
                end
            end
            PS_MEM_WAIT: begin
                drop = bus.rx_rcv;
                if (!bus.mem_busy) begin
                    wr_req_c = (cmd == CMD_WRITE);
                    rd_req_c = (cmd == CMD_READ_REQ);
                    ser_load = 1'b1;
                    state_nx = PS_RESP;
                end
            end
            PS_RESP: begin
                drop = bus.rx_rcv;
                if (ser_done)
                    state_nx = PS_RX;
            end
            default: state_nx = PS_RX;
        endcase
    end

    // Response reflects the value being written, so ADDR/LOAD echo the frame data directly
    always_comb begin
        resp = RESP_BAD;
        case (cmd)
            CMD_ADDR:     resp = data;
            CMD_LOAD:     resp = data;
            CMD_WRITE:    resp = RESP_WRITE;
            CMD_READ:     resp = rd_latch;
            CMD_READ_REQ: resp = RESP_READ_REQ;
            CMD_COUNT:    resp = count;
            CMD_CONST:    resp = RESP_CONST;
            default:      resp = RESP_BAD;
        endcase
    end

    hram_resp_serializer u_ser (
        .clk      (clk),
        .rstn     (rstn),
        .load     (ser_load),
        .resp_in  (resp),
        .tx_ready (bus.tx_ready),
        .tx_start (ser_tx_start),
        .tx_data  (ser_tx_data),
        .busy     (ser_busy),
        .done     (ser_done)
    );

    assign bus.tx_start  = ser_tx_start;
    assign bus.tx_data   = ser_tx_data;
    assign bus.addr      = addr_q;
    assign bus.wr_d      = wr_d_q;
    assign bus.wr_req    = wr_req_c;
    assign bus.rd_req    = rd_req_c;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_hram_cmd_parser.sv
// tb/tb_hram_cmd_parser.sv - randomized self-checking bench for hram_cmd_parser
module tb_hram_cmd_parser;

    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    hram_cmd_parser_if bus();

    hram_cmd_parser #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(22)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  partial[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] m_addr, m_wr, m_rd, m_cnt, last_resp, next_rd;
    bit          m_ferr, in_resp, uart_busy;
    int          pend_wr, pend_rd, last_cyc, cyc;
    int          tx_cnt, wr_cnt, rd_cnt;
    logic [7:0]  e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        partial.delete();
        exp_tx.delete();
        m_addr = 0; m_wr = 0; m_rd = 0; m_cnt = 0;
        m_ferr = 0; in_resp = 0; pend_wr = 0; pend_rd = 0;
    endtask

    task automatic model_exec(input logic [7:0] c, input logic [31:0] d);
        logic [31:0] r;
        case (c)
            8'h01: begin m_addr = d; r = d; end
            8'h02: begin m_wr = d; r = d; end
            8'h03: begin pend_wr++; r = 32'd3; end
            8'h04: r = m_rd;
            8'h05: begin pend_rd++; r = 32'd5; end
            8'h06: begin r = m_cnt; m_cnt = m_cnt + 1; end
            8'h07: r = 32'h103;
            default: r = 32'hFFFF_FFFF;
        endcase
        last_resp = r;
        for (int i = 3; i >= 0; i--) exp_tx.push_back(r[i*8 +: 8]);
    endtask

    task automatic model_rx(input logic [7:0] b);
        if (in_resp) begin
            m_ferr = 1;
            return;
        end
`ifdef CMD_TIMEOUT_EN
        if (partial.size() != 0 && cyc - last_cyc >= TIMEOUT) partial.delete();
`endif
        partial.push_back(b);
        last_cyc = cyc;
        if (partial.size() == 5) begin
            model_exec(partial[0], {partial[1], partial[2], partial[3], partial[4]});
            partial.delete();
            in_resp = 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_rcv  = 1'b1;
        model_rx(b);
        @(posedge clk); #1;
        bus.rx_rcv  = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] d, input int busy_n, input int gapmax);
        for (int i = 0; i < 5; i++) begin
            if (i == 4 && busy_n > 0) bus.mem_busy = 1'b1;
            send_byte(i == 0 ? c : d[8*(4-i) +: 8]);
            if (i < 4) repeat ($urandom_range(0, gapmax)) @(posedge clk);
        end
        if (busy_n > 0) begin
            repeat (busy_n) @(posedge clk);
            #1 bus.mem_busy = 1'b0;
        end
    endtask

    task automatic wait_resp();
        int n = 0;
        while ((exp_tx.size() != 0 || uart_busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("resp_within_budget", n < 3000, 1'b1);
        exp_tx.delete();
        repeat (3) @(posedge clk);
        #1;
        in_resp = 0;
        chk("frame_err", bus.frame_err, m_ferr);
        chk("addr", bus.addr, m_addr);
        chk("wr_d", bus.wr_d, m_wr);
        chk("wr_req_issued", pend_wr, 0);
        chk("rd_req_issued", pend_rd, 0);
    endtask

    // uart_tx stand-in: drops tx_ready 1-2 cycles after a start, holds it low a few cycles
    initial begin
        bus.tx_ready = 1'b1;
        uart_busy = 0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && bus.tx_start === 1'b1) begin
                uart_busy = 1;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1 bus.tx_ready = 1'b0;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1 bus.tx_ready = 1'b1;
                uart_busy = 0;
            end
        end
    end

    // hyper_xface read stand-in: returns next_rd a few cycles after each rd_req
    initial begin
        bus.rd_rdy = 1'b0;
        bus.rd_d   = '0;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && bus.rd_req === 1'b1) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                bus.rd_d   = next_rd;
                bus.rd_rdy = 1'b1;
                m_rd       = next_rd;
                @(posedge clk); #1;
                bus.rd_rdy = 1'b0;
                bus.rd_d   = $urandom;
                next_rd    = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (bus.tx_start) begin
                tx_cnt++;
                chk("tx_byte_expected", exp_tx.size() != 0, 1'b1);
                if (exp_tx.size() != 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_data", bus.tx_data, e);
                end
            end
            if (bus.wr_req) begin
                wr_cnt++;
                chk("wr_req_while_busy", bus.mem_busy, 1'b0);
                chk("wr_req_expected", pend_wr > 0, 1'b1);
                if (pend_wr > 0) pend_wr--;
                chk("wr_req_wr_d", bus.wr_d, m_wr);
                chk("wr_req_addr", bus.addr, m_addr);
            end
            if (bus.rd_req) begin
                rd_cnt++;
                chk("rd_req_while_busy", bus.mem_busy, 1'b0);
                chk("rd_req_expected", pend_rd > 0, 1'b1);
                if (pend_rd > 0) pend_rd--;
                chk("rd_req_addr", bus.addr, m_addr);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int t0, sel, busy_n;
        logic [7:0] c;

        cyc = 0; tx_cnt = 0; wr_cnt = 0; rd_cnt = 0; last_cyc = 0;
        next_rd = $urandom;
        bus.rx_rcv = 1'b0; bus.rx_data = '0; bus.mem_busy = 1'b0;
        model_reset();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr", bus.addr, 32'h0);
        chk("reset_wr_d", bus.wr_d, 32'h0);
        chk("reset_tx_start", bus.tx_start, 1'b0);
        chk("reset_tx_data", bus.tx_data, 8'h00);
        chk("reset_wr_req", bus.wr_req, 1'b0);
        chk("reset_rd_req", bus.rd_req, 1'b0);
        chk("reset_frame_err", bus.frame_err, 1'b0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // set address, echoed MSB first
        t0 = tx_cnt;
        send_frame(8'h01, 32'h1234_5678, 0, 3);
        chk("pin_addr_resp", last_resp, 32'h1234_5678);
        wait_resp();
        chk("addr_literal", bus.addr, 32'h1234_5678);
        chk("addr_tx_count", tx_cnt - t0, 4);

        // write held off by a busy memory
        send_frame(8'h02, 32'hDEAD_BEEF, 0, 3);
        wait_resp();
        t0 = wr_cnt;
        send_frame(8'h03, 32'h0, 10, 3);
        chk("pin_write_resp", last_resp, 32'h3);
        wait_resp();
        chk("wr_d_literal", bus.wr_d, 32'hDEAD_BEEF);
        chk("wr_req_pulses", wr_cnt - t0, 1);

        // read request then read back of the latched data
        next_rd = 32'hCAFE_F00D;
        t0 = rd_cnt;
        send_frame(8'h05, $urandom, 4, 3);
        chk("pin_read_req_resp", last_resp, 32'h5);
        wait_resp();
        chk("rd_req_pulses", rd_cnt - t0, 1);
        send_frame(8'h04, $urandom, 0, 3);
        chk("pin_read_resp", last_resp, 32'hCAFE_F00D);
        wait_resp();

        // counter, unknown command, constant
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h06, $urandom, 0, 2);
            chk("pin_count_resp", last_resp, i);
            wait_resp();
        end
        send_frame(8'h99, $urandom, 0, 2);
        chk("pin_bad_resp", last_resp, 32'hFFFF_FFFF);
        wait_resp();
        send_frame(8'h07, $urandom, 0, 2);
        chk("pin_const_resp", last_resp, 32'h103);
        wait_resp();

        // byte arriving during a response is dropped and flagged
        send_frame(8'h07, $urandom, 0, 2);
        t0 = 0;
        while (exp_tx.size() > 3 && t0 < 2000) begin
            @(posedge clk); #1;
            t0++;
        end
        send_byte(8'h55);
        wait_resp();
        chk("frame_err_literal", bus.frame_err, 1'b1);
        send_frame(8'h01, 32'h0BAD_F00D, 0, 2);
        wait_resp();

        // asynchronous reset after three bytes of a frame
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        chk("midreset_addr", bus.addr, 32'h0);
        chk("midreset_wr_d", bus.wr_d, 32'h0);
        chk("midreset_frame_err", bus.frame_err, 1'b0);
        chk("midreset_tx_start", bus.tx_start, 1'b0);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        send_frame(8'h06, $urandom, 0, 2);
        chk("pin_count_after_reset", last_resp, 32'h0);
        wait_resp();

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 8);
            c = (sel == 8) ? 8'($urandom_range(8, 255)) : 8'(sel);
            busy_n = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
            send_frame(c, $urandom, busy_n, 6);
            wait_resp();
        end

        // partial frame followed by a long idle gap
        send_byte(8'h01);
        send_byte(8'hAB);
        repeat (120) @(posedge clk);
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h03);
`ifdef CMD_TIMEOUT_EN
        chk("pin_timeout_resp", last_resp, 32'h103);
`else
        chk("pin_misaligned_resp", last_resp, 32'hAB07_0000);
`endif
        wait_resp();
        chk("tx_queue_drained", exp_tx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
